// File: rtl/mem_traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_traffic_pkg
// Description : Shared types and helpers for the memory traffic checker:
//               run-state encoding, request-type constants and the Galois
//               LFSR tap mask used when MEM_TRAFFIC_LFSR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WAIT_WR = 3'd2,
        ST_READ    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // Right-shifting Galois LFSR feedback masks (maximal length for the
    // listed widths; other widths get a simple non-degenerate mask).
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 64'h0000_0000_0000_000C;
            8:       lfsr_taps = 64'h0000_0000_0000_00B8;
            12:      lfsr_taps = 64'h0000_0000_0000_0E08;
            16:      lfsr_taps = 64'h0000_0000_0000_B400;
            24:      lfsr_taps = 64'h0000_0000_00E1_0000;
            32:      lfsr_taps = 64'h0000_0000_8020_0003;
            default: lfsr_taps = (64'd1 << (width - 1)) | 64'd3;
        endcase
    endfunction

endpackage : mem_traffic_pkg
`default_nettype wire

// File: rtl/mem_traffic_pattern.sv
`default_nettype none
// ============================================================================
// Module      : mem_traffic_pattern
// Description : Data pattern source. Default build: pattern = index resized
//               to DATA_WIDTH. With MEM_TRAFFIC_LFSR_EN defined: a Galois
//               LFSR seeded with 1 on reseed and stepped on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_traffic_pattern
    import mem_traffic_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reseed,
    input  logic                   advance,
    input  logic [COUNT_WIDTH-1:0] idx,
    output logic [DATA_WIDTH-1:0]  pattern
);

`ifdef MEM_TRAFFIC_LFSR_EN
    localparam logic [DATA_WIDTH-1:0] c_lfsr_taps = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] r_lfsr;

    // The index is implied by the number of advances in this mode.
    logic w_unused;
    assign w_unused = &{1'b0, idx};

    // LFSR state: reseed wins over advance so a start always restarts the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= '0;
        end else if (reseed) begin
            r_lfsr <= DATA_WIDTH'(1);
        end else if (advance) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_taps) : (r_lfsr >> 1);
        end
    end

    assign pattern = r_lfsr;
`else
    // Counting pattern needs no state; the sequencing inputs are unused.
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, reseed, advance};

    assign pattern = DATA_WIDTH'(idx);
`endif

endmodule : mem_traffic_pattern
`default_nettype wire

// File: rtl/mem_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_traffic_checker
// Description : Request generator and read-back checker for the memory
//               controller user port. Writes num_req words from base_addr,
//               waits for every write_done, reads them back in order and
//               compares each read word against the regenerated pattern.
//               Reports pass, error count, cycle count and idle timeout.
//               Optional macro: MEM_TRAFFIC_LFSR_EN selects an LFSR pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_traffic_checker
    import mem_traffic_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 30,
    parameter int COUNT_WIDTH  = 16,
    parameter int CYCLE_WIDTH  = 32,
    parameter int ADDR_STRIDE  = 1,
    parameter int IDLE_TIMEOUT = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_req,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic                   out_busy,
    output logic                   in_valid,
    output logic                   in_request_type,
    output logic [ADDR_WIDTH-1:0]  in_request_address,
    output logic [DATA_WIDTH-1:0]  in_request_data,
    input  logic                   write_done,
    input  logic                   read_done,
    input  logic [DATA_WIDTH-1:0]  data_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [COUNT_WIDTH-1:0] r_num_req;
    logic [ADDR_WIDTH-1:0]  r_base_addr;
    logic [COUNT_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [COUNT_WIDTH-1:0] r_wr_cnt;
    logic [COUNT_WIDTH-1:0] r_exp_idx;
    logic [IDLE_W-1:0]      r_idle;
    logic                   r_timeout;
    logic [COUNT_WIDTH-1:0] r_err;
    logic [CYCLE_WIDTH-1:0] r_cycles;

    logic                   w_busy_st;
    logic                   w_start_ok;
    logic                   w_last_req;
    logic                   w_wr_count;
    logic                   w_wr_extra;
    logic                   w_rd_check;
    logic                   w_rd_count;
    logic                   w_rd_extra;
    logic                   w_rd_mismatch;
    logic                   w_idle_hit;
    logic [1:0]             w_err_inc;
    logic [COUNT_WIDTH:0]   w_err_sum;
    logic [DATA_WIDTH-1:0]  w_gen_data;
    logic [DATA_WIDTH-1:0]  w_exp_data;

    assign w_busy_st  = (r_state == ST_WRITE) || (r_state == ST_WAIT_WR) ||
                        (r_state == ST_READ)  || (r_state == ST_DRAIN);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign in_valid   = ((r_state == ST_WRITE) || (r_state == ST_READ)) && !out_busy;
    assign w_last_req = in_valid && (r_idx == r_num_req - COUNT_WIDTH'(1));

    // Completion accounting: anything beyond num_req is a protocol error.
    assign w_wr_count    = write_done && w_busy_st && (r_wr_cnt != r_num_req);
    assign w_wr_extra    = write_done && w_busy_st && (r_wr_cnt == r_num_req);
    assign w_rd_check    = read_done && ((r_state == ST_READ) || (r_state == ST_DRAIN));
    assign w_rd_count    = w_rd_check && (r_exp_idx != r_num_req);
    assign w_rd_extra    = w_rd_check && (r_exp_idx == r_num_req);
    assign w_rd_mismatch = w_rd_count && (data_out != w_exp_data);

    assign w_idle_hit = ((r_state == ST_WAIT_WR) || (r_state == ST_DRAIN)) &&
                        !write_done && !read_done &&
                        (r_idle == IDLE_W'(IDLE_TIMEOUT - 1));

    assign w_err_inc = {1'b0, w_wr_extra} + {1'b0, w_rd_extra} + {1'b0, w_rd_mismatch};
    assign w_err_sum = {1'b0, r_err} + (COUNT_WIDTH + 1)'(w_err_inc);

    // Generator pattern steps with each accepted write.
    mem_traffic_pattern #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_gen_pattern (
        .clk     (clk),
        .rst_n   (rst_n),
        .reseed  (w_start_ok),
        .advance (in_valid && (r_state == ST_WRITE)),
        .idx     (r_idx),
        .pattern (w_gen_data)
    );

    // Checker pattern steps with each in-range returned read word.
    mem_traffic_pattern #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_chk_pattern (
        .clk     (clk),
        .rst_n   (rst_n),
        .reseed  (w_start_ok),
        .advance (w_rd_count),
        .idx     (r_exp_idx),
        .pattern (w_exp_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: write phase, wait for all write_done, read phase, drain.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_ok) w_next = (num_req == '0) ? ST_DONE : ST_WRITE;
            ST_WRITE:         if (w_last_req) w_next = ST_WAIT_WR;
            ST_WAIT_WR: begin
                if (r_wr_cnt == r_num_req) w_next = ST_READ;
                else if (w_idle_hit)       w_next = ST_DONE;
            end
            ST_READ:          if (w_last_req) w_next = ST_DRAIN;
            ST_DRAIN: begin
                if (r_exp_idx == r_num_req) w_next = ST_DONE;
                else if (w_idle_hit)        w_next = ST_DONE;
            end
            default:          w_next = ST_IDLE;
        endcase
    end

    // Run configuration captured on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_req   <= '0;
            r_base_addr <= '0;
        end else if (w_start_ok) begin
            r_num_req   <= num_req;
            r_base_addr <= base_addr;
        end
    end

    // Request index and address; both rewind to the base after the last request of a phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_addr <= '0;
        end else if (w_start_ok) begin
            r_idx  <= '0;
            r_addr <= base_addr;
        end else if (w_last_req) begin
            r_idx  <= '0;
            r_addr <= r_base_addr;
        end else if (in_valid) begin
            r_idx  <= r_idx + COUNT_WIDTH'(1);
            r_addr <= r_addr + ADDR_WIDTH'(ADDR_STRIDE);
        end
    end

    // Write completion and read expectation counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_exp_idx <= '0;
        end else if (w_start_ok) begin
            r_wr_cnt  <= '0;
            r_exp_idx <= '0;
        end else begin
            if (w_wr_count) r_wr_cnt  <= r_wr_cnt + COUNT_WIDTH'(1);
            if (w_rd_count) r_exp_idx <= r_exp_idx + COUNT_WIDTH'(1);
        end
    end

    // Idle watchdog: counts quiet cycles while completions are outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (w_start_ok || (w_next != r_state) || write_done || read_done) begin
            r_idle <= '0;
        end else if ((r_state == ST_WAIT_WR) || (r_state == ST_DRAIN)) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    // Timeout flag, error count (saturating) and cycle count (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
            r_err     <= '0;
            r_cycles  <= '0;
        end else if (w_start_ok) begin
            r_timeout <= 1'b0;
            r_err     <= '0;
            r_cycles  <= '0;
        end else begin
            if (w_idle_hit) r_timeout <= 1'b1;
            r_err <= w_err_sum[COUNT_WIDTH] ? '1 : w_err_sum[COUNT_WIDTH-1:0];
            if (w_busy_st && (r_cycles != '1)) r_cycles <= r_cycles + CYCLE_WIDTH'(1);
        end
    end

    assign in_request_type    = (r_state == ST_WRITE) ? REQ_WRITE : REQ_READ;
    assign in_request_address = r_addr;
    assign in_request_data    = w_gen_data;
    assign busy               = w_busy_st;
    assign done               = (r_state == ST_DONE);
    assign pass               = done && !r_timeout && (r_err == '0);
    assign timeout            = r_timeout;
    assign error_count        = r_err;
    assign cycle_count        = r_cycles;

endmodule : mem_traffic_checker
`default_nettype wire

// File: tb/tb_mem_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_traffic_checker
// Description : Self-checking bench for mem_traffic_checker. A behavioural
//               memory responder answers requests with random latency; a
//               reference model predicts every request and the final report.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_traffic_checker;

    localparam int DW     = 16;
    localparam int AW     = 30;
    localparam int CW     = 16;
    localparam int YW     = 32;
    localparam int STRIDE = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_req;
    logic [AW-1:0] base_addr;
    logic          out_busy;
    logic          in_valid;
    logic          in_request_type;
    logic [AW-1:0] in_request_address;
    logic [DW-1:0] in_request_data;
    logic          write_done;
    logic          read_done;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [CW-1:0] error_count;
    logic [YW-1:0] cycle_count;

    mem_traffic_checker #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .COUNT_WIDTH  (CW),
        .CYCLE_WIDTH  (YW),
        .ADDR_STRIDE  (STRIDE),
        .IDLE_TIMEOUT (200)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .num_req            (num_req),
        .base_addr          (base_addr),
        .out_busy           (out_busy),
        .in_valid           (in_valid),
        .in_request_type    (in_request_type),
        .in_request_address (in_request_address),
        .in_request_data    (in_request_data),
        .write_done         (write_done),
        .read_done          (read_done),
        .data_out           (data_out),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .timeout            (timeout),
        .error_count        (error_count),
        .cycle_count        (cycle_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference pattern for word i of a run.
    function automatic logic [DW-1:0] pat(input int i);
`ifdef MEM_TRAFFIC_LFSR_EN
        logic [DW-1:0] s;
        s = 1;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return s;
`else
        return DW'(i);
`endif
    endfunction

    // Responder and model state.
    int            cyc = 0;
    int            wr_due[$];
    int            rd_due[$];
    logic [DW-1:0] rd_dat[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            n_cur;
    logic [AW-1:0] base_cur;
    int            wr_acc, rd_acc, busy_cyc, last_rd_cyc;
    int            corrupt_at  = -1;
    bit            no_read_resp = 0;
    bit            rand_busy    = 0;
    bit            start_req    = 0;
    int            hold_left    = 0;
    bit            hold_mode    = 0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    function automatic logic [AW-1:0] exp_addr(input int i);
        return base_cur + AW'(i * STRIDE);
    endfunction

    task automatic accept_req();
        logic [DW-1:0] d;
        if (wr_acc < n_cur) begin
            check_eq("wr_type", 64'(in_request_type), 64'd1);
            check_eq("wr_addr", 64'(in_request_address), 64'(exp_addr(wr_acc)));
            check_eq("wr_data", 64'(in_request_data), 64'(pat(wr_acc)));
            mem[in_request_address] = in_request_data;
            wr_due.push_back(cyc + int'($urandom_range(1, 4)));
            wr_acc++;
        end else if (rd_acc < n_cur) begin
            check_eq("rd_type", 64'(in_request_type), 64'd0);
            check_eq("rd_addr", 64'(in_request_address), 64'(exp_addr(rd_acc)));
            d = mem.exists(in_request_address) ? mem[in_request_address] : '0;
            if (rd_acc == corrupt_at) d = 16'hFFFF;
            if (!no_read_resp) begin
                rd_due.push_back(cyc + int'($urandom_range(1, 5)));
                rd_dat.push_back(d);
            end
            last_rd_cyc = cyc;
            rd_acc++;
        end else begin
            check_eq("extra_req", 64'd1, 64'd0);
        end
    endtask

    // One clock: drive inputs at the falling edge, observe 1 ns later.
    task automatic run_cycle();
        @(negedge clk);
        cyc++;
        start     = start_req;
        start_req = 0;
        write_done = 1'b0;
        if (wr_due.size() > 0 && wr_due[0] <= cyc) begin
            void'(wr_due.pop_front());
            write_done = 1'b1;
        end
        read_done = 1'b0;
        if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
            void'(rd_due.pop_front());
            data_out  = rd_dat.pop_front();
            read_done = 1'b1;
        end
        if (hold_left > 0) begin
            out_busy = 1'b1;
            hold_left--;
        end else begin
            out_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        #1;
        if (busy) busy_cyc++;
        if (hold_mode) begin
            check_eq("hold_valid", 64'(in_valid), 64'd0);
            check_eq("hold_addr", 64'(in_request_address), 64'(hold_addr));
            check_eq("hold_data", 64'(in_request_data), 64'(hold_data));
        end
        if (in_valid) accept_req();
    endtask

    task automatic start_run(input int n, input logic [AW-1:0] base);
        num_req   = CW'(n);
        base_addr = base;
        n_cur     = n;
        base_cur  = base;
        wr_acc    = 0;
        rd_acc    = 0;
        busy_cyc  = 0;
        start_req = 1;
        run_cycle();
        run_cycle();
        check_eq("done_after_start", 64'(done), (n == 0) ? 64'd1 : 64'd0);
    endtask

    task automatic finish_run(input bit exp_pass, input bit exp_to, input int exp_err);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            run_cycle();
            k++;
        end
        check_eq("run_done", 64'(done), 64'd1);
        check_eq("busy_at_done", 64'(busy), 64'd0);
        check_eq("pass", 64'(pass), 64'(exp_pass));
        check_eq("timeout", 64'(timeout), 64'(exp_to));
        check_eq("error_count", 64'(error_count), 64'(exp_err));
        check_eq("cycle_count", 64'(cycle_count), 64'(busy_cyc));
        check_eq("writes_issued", 64'(wr_acc), 64'(n_cur));
        check_eq("reads_issued", 64'(rd_acc), 64'(n_cur));
    endtask

    initial begin
        int            n;
        int            ca;
        int            e;
        logic [AW-1:0] b;

        rst_n = 1'b0; start = 1'b0; num_req = '0; base_addr = '0;
        out_busy = 1'b0; write_done = 1'b0; read_done = 1'b0; data_out = '0;
        run_cycle();
        run_cycle();
        check_eq("rst_valid", 64'(in_valid), 64'd0);
        check_eq("rst_flags", 64'({busy, done, pass, timeout}), 64'd0);
        check_eq("rst_err", 64'(error_count), 64'd0);
        check_eq("rst_cycles", 64'(cycle_count), 64'd0);
        rst_n = 1'b1;
        run_cycle();

        // Basic run: 4 words at address 2.
        start_run(4, AW'(2));
        finish_run(1, 0, 0);
        repeat (3) run_cycle();
        check_eq("done_held", 64'(done), 64'd1);

        // out_busy held for 5 cycles in the middle of the write phase.
        start_run(16, AW'(100));
        for (int k = 0; k < 200 && wr_acc < 6; k++) run_cycle();
        check_eq("reach_mid_write", 64'(wr_acc), 64'd6);
        hold_addr = exp_addr(wr_acc);
        hold_data = pat(wr_acc);
        hold_left = 5;
        hold_mode = 1;
        repeat (5) run_cycle();
        hold_mode = 0;
        finish_run(1, 0, 0);

        // Third read word corrupted.
        corrupt_at = 2;
        start_run(8, AW'(40));
        finish_run(0, 0, 1);
        corrupt_at = -1;

        // No read responses: idle timeout 200 cycles after the last read accept.
        no_read_resp = 1;
        start_run(2, AW'(7));
        finish_run(0, 1, 0);
        check_eq("timeout_latency", 64'(cyc - last_rd_cyc), 64'd201);
        no_read_resp = 0;

        // Zero-length run.
        start_run(0, AW'(5));
        check_eq("zero_pass", 64'(pass), 64'd1);
        check_eq("zero_no_req", 64'(wr_acc + rd_acc), 64'd0);

        // Reset during the read phase, then a clean short run.
        start_run(10, AW'(300));
        for (int k = 0; k < 400 && rd_acc < 2; k++) run_cycle();
        check_eq("reach_read", 64'(rd_acc), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(in_valid), 64'd0);
        check_eq("midrst_flags", 64'({busy, done, pass, timeout, in_request_type}), 64'd0);
        check_eq("midrst_addr", 64'(in_request_address), 64'd0);
        check_eq("midrst_data", 64'(in_request_data), 64'd0);
        check_eq("midrst_counts", 64'({error_count, cycle_count}), 64'd0);
        wr_due.delete(); rd_due.delete(); rd_dat.delete();
        n_cur = 0;
        repeat (3) begin
            run_cycle();
            check_eq("rst_hold_valid", 64'(in_valid), 64'd0);
        end
        rst_n = 1'b1;
        start_run(3, AW'(20));
        finish_run(1, 0, 0);

        // Randomized runs with random back-pressure, address wrap and corruption.
        rand_busy = 1;
        for (int t = 0; t < 5; t++) begin
            n  = int'($urandom_range(1, 20));
            b  = ($urandom_range(0, 1) == 1) ? AW'($urandom) : ({AW{1'b1}} - AW'(2));
            ca = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            e  = (ca >= 0 && pat(ca) != 16'hFFFF) ? 1 : 0;
            corrupt_at = ca;
            start_run(n, b);
            finish_run(e == 0, 0, e);
        end
        corrupt_at = -1;
        rand_busy  = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_traffic_checker
`default_nettype wire
